// File: rtl/adder_64.sv
// rtl/adder_64.sv - registered 64-bit adder with carry, overflow and zero flags
// Define ADDER_SPLIT_PIPE_EN for the two-stage pipeline split at bit 32 (latency 2); otherwise latency 1.
module adder_64 (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    input  logic        in_valid,
    output logic [63:0] out,
    output logic        cout,
    output logic        overflow,
    output logic        zero,
    output logic        out_valid
);

    logic [63:0] out_d, out_q;
    logic        cout_d, cout_q;
    logic        ovf_d, ovf_q;
    logic        zero_d, zero_q;
    logic        valid_d, valid_q;

`ifdef ADDER_SPLIT_PIPE_EN
    logic [32:0] lo_d, lo_q;
    logic [31:0] a_hi_d, a_hi_q;
    logic [31:0] b_hi_d, b_hi_q;
    logic        v1_d, v1_q;
    logic [32:0] hi;

    always_comb begin
        lo_d   = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'd0, cin};
        a_hi_d = a[63:32];
        b_hi_d = b[63:32];
        v1_d   = in_valid;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo_q   <= '0;
            a_hi_q <= '0;
            b_hi_q <= '0;
            v1_q   <= 1'b0;
        end else begin
            lo_q   <= lo_d;
            a_hi_q <= a_hi_d;
            b_hi_q <= b_hi_d;
            v1_q   <= v1_d;
        end
    end

    // Upper half consumes the registered carry out of bit 31.
    always_comb begin
        hi      = {1'b0, a_hi_q} + {1'b0, b_hi_q} + {32'd0, lo_q[32]};
        out_d   = {hi[31:0], lo_q[31:0]};
        cout_d  = hi[32];
        ovf_d   = (a_hi_q[31] == b_hi_q[31]) && (hi[31] != a_hi_q[31]);
        valid_d = v1_q;
        zero_d  = (out_d == 64'd0);
    end
`else
    logic [64:0] sum;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        out_d   = sum[63:0];
        cout_d  = sum[64];
        ovf_d   = (a[63] == b[63]) && (sum[63] != a[63]);
        valid_d = in_valid;
        zero_d  = (out_d == 64'd0);
    end
`endif

    // zero clears on reset even though out is also cleared to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_adder_64.sv
// tb/tb_adder_64.sv - self-checking bench for adder_64 against a queue-based arithmetic model
module tb_adder_64;

`ifdef ADDER_SPLIT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        cin = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] out;
    logic        cout, overflow, zero, out_valid;
    logic [67:0] obs;

    int errors = 0;
    int checks = 0;

    logic [67:0] model_q[$];

    adder_64 dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
        .out(out), .cout(cout), .overflow(overflow), .zero(zero), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    assign obs = {out, cout, overflow, zero, out_valid};

    // Expected record {sum, carry, overflow, zero, valid} from plain 65-bit arithmetic.
    function automatic logic [67:0] model(input logic [63:0] ta, input logic [63:0] tb, input logic tc, input logic tv);
        logic [64:0] s;
        logic        ov;
        s  = {1'b0, ta} + {1'b0, tb} + 65'(tc);
        ov = (ta[63] == tb[63]) && (s[63] != ta[63]);
        return {s[63:0], s[64], ov, (s[63:0] == 64'd0), tv};
    endfunction

    // Drive one transaction, advance one edge; returns the record now expected on the outputs.
    task automatic step(input logic [63:0] ta, input logic [63:0] tb, input logic tc, input logic tv,
                        output logic have, output logic [67:0] e);
        a = ta; b = tb; cin = tc; in_valid = tv;
        @(posedge clk);
        model_q.push_back(model(ta, tb, tc, tv));
        have = 1'b0;
        e    = '0;
        if (model_q.size() == LAT) begin
            e    = model_q.pop_front();
            have = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (obs !== 68'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs, 68'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        model_q.delete();
        @(posedge clk);
        model_q.push_back(model(64'd0, 64'd0, 1'b0, 1'b0));
        if (model_q.size() == LAT) void'(model_q.pop_front());
        #1;
    endtask

    task automatic test_directed;
        logic [63:0] va[4], vb[4];
        logic        vc[4];
        logic [67:0] vexp[4];
        logic        have;
        logic [67:0] e;
        va[0] = 64'h1234567890ABCDEF; vb[0] = 64'hFEDCBA0987654321; vc[0] = 1'b0;
        vexp[0] = {64'h1111108218111110, 1'b1, 1'b0, 1'b0, 1'b1};
        va[1] = 64'h7FFFFFFFFFFFFFFF; vb[1] = 64'd1; vc[1] = 1'b0;
        vexp[1] = {64'h8000000000000000, 1'b0, 1'b1, 1'b0, 1'b1};
        va[2] = 64'hFFFFFFFFFFFFFFFF; vb[2] = 64'd0; vc[2] = 1'b1;
        vexp[2] = {64'h0, 1'b1, 1'b0, 1'b1, 1'b1};
        va[3] = 64'h00000000FFFFFFFF; vb[3] = 64'd1; vc[3] = 1'b0;
        vexp[3] = {64'h0000000100000000, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            step(va[i], vb[i], vc[i], 1'b1, have, e);
            for (int k = 1; k < LAT; k++) step(64'd0, 64'd0, 1'b0, 1'b0, have, e);
            checks++;
            if (obs !== vexp[i]) begin
                errors++;
                $display("FAIL directed_%0d: got %h expected %h", i, obs, vexp[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] sa[6], sb[6];
        logic        sv[6];
        logic [63:0] eo[4];
        logic        ev[4];
        logic        have;
        logic [67:0] e;
        int          idx;
        sa = '{64'd1, 64'd3, 64'd5, 64'd0, 64'd0, 64'd0};
        sb = '{64'd2, 64'd4, 64'd6, 64'd0, 64'd0, 64'd0};
        sv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        eo = '{64'd3, 64'd7, 64'd11, 64'd0};
        ev = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3 + LAT; i++) begin
            step(sa[i], sb[i], 1'b0, sv[i], have, e);
            idx = i - (LAT - 1);
            if (idx >= 0 && idx < 4) begin
                checks++;
                if (out_valid !== ev[idx] || (ev[idx] && out !== eo[idx])) begin
                    errors++;
                    $display("FAIL back_to_back_%0d: got out=%0d valid=%b expected out=%0d valid=%b",
                             idx, out, out_valid, eo[idx], ev[idx]);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [63:0] ra, rb;
        logic        rc, rv, have;
        logic [67:0] e;
        for (int i = 0; i < 300; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom);
            rv = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: begin ra[31:0] = 32'hFFFFFFFF; rb[31:0] = 32'd0; rc = 1'b1; end
                1: begin ra[63:32] = 32'hFFFFFFFF; rb[63:32] = 32'd0; end
                2: rb = ~ra + 64'(~rc);
                default: ;
            endcase
            step(ra, rb, rc, rv, have, e);
            checks++;
            if (have) begin
                if (obs !== e) begin
                    errors++;
                    $display("FAIL random_%0d: got %h expected %h", i, obs, e);
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL random_fill_%0d: got valid=%b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_reset_midflight;
        logic        have;
        logic [67:0] e;
        step(64'd10, 64'd20, 1'b0, 1'b1, have, e);
        a = 64'd30; b = 64'd40; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 64'd50; b = 64'd60;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== 68'd0) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", obs, 68'd0);
        end
        model_q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(64'd0, 64'd0, 1'b0, 1'b0, have, e);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_stale_%0d: got valid=%b expected 0", i, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
